cnn_feature_seq_buffer: RTL and testbench

Sits directly downstream of the CNN wrapper's FC output port (fc_output_data / fc_output_valid / fc_output_ready).
- Groups FC output words into feature frames of FEAT_SIZE words each.
- Keeps a sliding window of the last SEQ_LEN frames.
- After each new frame, once the window is full, replays the window to the BiLSTM front end twice: forward (oldest to newest), then backward (newest to oldest).
- Provides the time-ordered, bidirectional sequence the BiLSTM needs for localization.

---
 rtl/cnn_seq_pkg.sv | 22 ++
 rtl/seq_addr_gen.sv | 118 +++++++++++
 rtl/cnn_feature_seq_buffer.sv | 195 +++++++++++++++++++
 tb/tb_cnn_feature_seq_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and defaults for the CNN feature sequence buffer.
package cnn_seq_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int FEAT_SIZE_DEF  = 3;
   localparam int SEQ_LEN_DEF    = 8;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_FWD    = 2'd1,
      ST_BWD    = 2'd2
   } seq_state_e;

   // Index width that never collapses to zero bits for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SLOT_W_DEF = idx_w(SEQ_LEN_DEF);
   localparam int FEAT_W_DEF = idx_w(FEAT_SIZE_DEF);

endpackage

// File: rtl/seq_addr_gen.sv
// Replay address generator: (pass, step, feat) counters for the word on the output
// register, plus the physical slot of the next word; advances only on accepted words.
module seq_addr_gen
   import cnn_seq_pkg::*;
#(
   parameter int  FEAT_SIZE = FEAT_SIZE_DEF,
   parameter int  SEQ_LEN   = SEQ_LEN_DEF,
   localparam int SLOT_W    = idx_w(SEQ_LEN),
   localparam int FEAT_W    = idx_w(FEAT_SIZE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic              advance_i,
   input  logic [SLOT_W-1:0] oldest_slot_i,
   output logic              dir_o,
   output logic [SLOT_W-1:0] step_o,
   output logic [FEAT_W-1:0] feat_o,
   output logic              first_o,
   output logic              last_o,
   output logic [SLOT_W-1:0] nxt_slot_o,
   output logic [FEAT_W-1:0] nxt_feat_o,
   output logic              pass_done_o
);

   localparam logic [SLOT_W-1:0] STEP_MAX = SLOT_W'(SEQ_LEN - 1);
   localparam logic [FEAT_W-1:0] FEAT_MAX = FEAT_W'(FEAT_SIZE - 1);
   localparam logic [SLOT_W:0]   SLOTS    = (SLOT_W + 1)'(SEQ_LEN);

   logic              dir_q, dir_d;
   logic [SLOT_W-1:0] step_q, step_d;
   logic [FEAT_W-1:0] feat_q, feat_d;
   logic              first_q, first_d;
   logic              last_q, last_d;
   logic              end_of_pass;
   logic              load;
   logic [SLOT_W:0]   offset;
   logic [SLOT_W:0]   slot_sum;

   always_comb begin
      dir_d       = dir_q;
      step_d      = step_q;
      feat_d      = feat_q;
      first_d     = first_q;
      last_d      = last_q;
      load        = 1'b0;
      end_of_pass = (step_q == STEP_MAX) && (feat_q == FEAT_MAX);
      pass_done_o = advance_i && end_of_pass && dir_q;

      if (clear_i || pass_done_o) begin
         dir_d   = 1'b0;
         step_d  = '0;
         feat_d  = '0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end else if (start_i) begin
         dir_d  = 1'b0;
         step_d = '0;
         feat_d = '0;
         load   = 1'b1;
      end else if (advance_i) begin
         load = 1'b1;
         if (feat_q == FEAT_MAX) begin
            feat_d = '0;
            // End of the forward pass rolls straight into the backward pass.
            if (step_q == STEP_MAX) begin
               step_d = '0;
               dir_d  = 1'b1;
            end else begin
               step_d = step_q + 1'b1;
            end
         end else begin
            feat_d = feat_q + 1'b1;
         end
      end

      if (load) begin
         first_d = (step_d == '0) && (feat_d == '0);
         last_d  = (step_d == STEP_MAX) && (feat_d == FEAT_MAX);
      end
   end

   // Backward pass walks from the newest slot, i.e. oldest + SEQ_LEN-1, downwards.
   always_comb begin
      offset   = dir_d ? {1'b0, STEP_MAX - step_d} : {1'b0, step_d};
      slot_sum = {1'b0, oldest_slot_i} + offset;
      if (slot_sum >= SLOTS) begin
         nxt_slot_o = SLOT_W'(slot_sum - SLOTS);
      end else begin
         nxt_slot_o = slot_sum[SLOT_W-1:0];
      end
      nxt_feat_o = feat_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q   <= 1'b0;
         step_q  <= '0;
         feat_q  <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         dir_q   <= dir_d;
         step_q  <= step_d;
         feat_q  <= feat_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign dir_o   = dir_q;
   assign step_o  = step_q;
   assign feat_o  = feat_q;
   assign first_o = first_q;
   assign last_o  = last_q;

endmodule

// File: rtl/cnn_feature_seq_buffer.sv
// Frames FC output words into a sliding SEQ_LEN window and replays it forward then backward
// on each new frame; output registered (valid 1 cycle after commit), input stalled during replay.
module cnn_feature_seq_buffer
   import cnn_seq_pkg::*;
#(
   parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int  FEAT_SIZE  = FEAT_SIZE_DEF,
   parameter int  SEQ_LEN    = SEQ_LEN_DEF,
   localparam int SLOT_W     = idx_w(SEQ_LEN),
   localparam int FEAT_W     = idx_w(FEAT_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] feat_in_data,
   input  logic                  feat_in_valid,
   output logic                  feat_in_ready,
   input  logic                  seq_flush,
   output logic [DATA_WIDTH-1:0] seq_data,
   output logic                  seq_valid,
   input  logic                  seq_ready,
   output logic                  seq_dir,
   output logic [SLOT_W-1:0]     seq_step,
   output logic [FEAT_W-1:0]     seq_feat_idx,
   output logic                  seq_first,
   output logic                  seq_last,
   output logic                  window_full,
   output logic [15:0]           seq_count
);

   localparam int                HELD_W    = $clog2(SEQ_LEN + 1);
   localparam logic [HELD_W-1:0] HELD_FULL = HELD_W'(SEQ_LEN);
   localparam logic [HELD_W-1:0] HELD_PRE  = HELD_W'(SEQ_LEN - 1);
   localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(SEQ_LEN - 1);
   localparam logic [FEAT_W-1:0] FEAT_MAX  = FEAT_W'(FEAT_SIZE - 1);

   logic [DATA_WIDTH-1:0] mem_q [SEQ_LEN][FEAT_SIZE];

   seq_state_e            state_q, state_d;
   logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
   logic [FEAT_W-1:0]     feat_idx_q, feat_idx_d;
   logic [HELD_W-1:0]     frames_held_q, frames_held_d;
   logic                  window_full_q, window_full_d;
   logic                  seq_valid_q, seq_valid_d;
   logic [DATA_WIDTH-1:0] seq_data_q, seq_data_d;
   logic [15:0]           seq_count_q, seq_count_d;

   logic                  in_ready;
   logic                  in_fire;
   logic                  commit_fire;
   logic                  out_fire;
   logic [SLOT_W-1:0]     wr_slot_nxt;
   logic [SLOT_W-1:0]     oldest_slot;
   logic                  ag_start;
   logic                  ag_advance;
   logic                  ag_dir;
   logic [SLOT_W-1:0]     ag_step;
   logic [FEAT_W-1:0]     ag_feat;
   logic                  ag_first;
   logic                  ag_last;
   logic [SLOT_W-1:0]     ag_nxt_slot;
   logic [FEAT_W-1:0]     ag_nxt_feat;
   logic                  ag_pass_done;

   assign in_ready    = (state_q == ST_ACCEPT) && !seq_flush;
   assign in_fire     = feat_in_valid && in_ready;
   assign commit_fire = in_fire && (feat_idx_q == FEAT_MAX);
   assign out_fire    = seq_valid_q && seq_ready;
   assign wr_slot_nxt = (wr_slot_q == SLOT_MAX) ? '0 : wr_slot_q + 1'b1;

   // Replay starts on the commit that fills (or keeps full) the window; the slot about to be
   // overwritten next is then the oldest one.
   assign ag_start    = commit_fire && (frames_held_q >= HELD_PRE);
   assign ag_advance  = out_fire && !seq_flush;
   assign oldest_slot = commit_fire ? wr_slot_nxt : (window_full_q ? wr_slot_q : '0);

   seq_addr_gen #(
      .FEAT_SIZE (FEAT_SIZE),
      .SEQ_LEN   (SEQ_LEN)
   ) u_addr_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (seq_flush),
      .start_i       (ag_start),
      .advance_i     (ag_advance),
      .oldest_slot_i (oldest_slot),
      .dir_o         (ag_dir),
      .step_o        (ag_step),
      .feat_o        (ag_feat),
      .first_o       (ag_first),
      .last_o        (ag_last),
      .nxt_slot_o    (ag_nxt_slot),
      .nxt_feat_o    (ag_nxt_feat),
      .pass_done_o   (ag_pass_done)
   );

   always_comb begin
      state_d       = state_q;
      wr_slot_d     = wr_slot_q;
      feat_idx_d    = feat_idx_q;
      frames_held_d = frames_held_q;
      seq_valid_d   = seq_valid_q;
      seq_count_d   = seq_count_q;

      if (seq_flush) begin
         state_d       = ST_ACCEPT;
         wr_slot_d     = '0;
         feat_idx_d    = '0;
         frames_held_d = '0;
         seq_valid_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (commit_fire) begin
                  feat_idx_d = '0;
                  wr_slot_d  = wr_slot_nxt;
                  if (frames_held_q != HELD_FULL) begin
                     frames_held_d = frames_held_q + 1'b1;
                  end
                  if (ag_start) begin
                     state_d     = ST_FWD;
                     seq_valid_d = 1'b1;
                  end
               end else if (in_fire) begin
                  feat_idx_d = feat_idx_q + 1'b1;
               end
            end
            ST_FWD: begin
               if (out_fire && ag_last) begin
                  state_d = ST_BWD;
               end
            end
            ST_BWD: begin
               if (ag_pass_done) begin
                  state_d     = ST_ACCEPT;
                  seq_valid_d = 1'b0;
                  seq_count_d = seq_count_q + 16'd1;
               end
            end
            default: begin
               state_d     = ST_ACCEPT;
               seq_valid_d = 1'b0;
            end
         endcase
      end

      window_full_d = (frames_held_d == HELD_FULL);
   end

   always_comb begin
      seq_data_d = seq_data_q;
      if (ag_start || (ag_advance && !ag_pass_done)) begin
         seq_data_d = mem_q[ag_nxt_slot][ag_nxt_feat];
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem_q[wr_slot_q][feat_idx_q] <= feat_in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_ACCEPT;
         wr_slot_q     <= '0;
         feat_idx_q    <= '0;
         frames_held_q <= '0;
         window_full_q <= 1'b0;
         seq_valid_q   <= 1'b0;
         seq_data_q    <= '0;
         seq_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         wr_slot_q     <= wr_slot_d;
         feat_idx_q    <= feat_idx_d;
         frames_held_q <= frames_held_d;
         window_full_q <= window_full_d;
         seq_valid_q   <= seq_valid_d;
         seq_data_q    <= seq_data_d;
         seq_count_q   <= seq_count_d;
      end
   end

   assign feat_in_ready = in_ready;
   assign seq_data      = seq_data_q;
   assign seq_valid     = seq_valid_q;
   assign seq_dir       = ag_dir;
   assign seq_step      = ag_step;
   assign seq_feat_idx  = ag_feat;
   assign seq_first     = ag_first;
   assign seq_last      = ag_last;
   assign window_full   = window_full_q;
   assign seq_count     = seq_count_q;

endmodule

// File: tb/tb_cnn_feature_seq_buffer.sv
// Bench for cnn_feature_seq_buffer: directed table, corner sequences and random traffic
// checked every cycle against a frame-queue reference model.
module tb_cnn_feature_seq_buffer;

   localparam int DW     = 16;
   localparam int FS     = 3;
   localparam int SL     = 8;
   localparam int REPLAY = 2 * SL * FS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] feat_in_data = '0;
   logic          feat_in_valid = 1'b0;
   logic          feat_in_ready;
   logic          seq_flush = 1'b0;
   logic [DW-1:0] seq_data;
   logic          seq_valid;
   logic          seq_ready = 1'b0;
   logic          seq_dir;
   logic [2:0]    seq_step;
   logic [1:0]    seq_feat_idx;
   logic          seq_first;
   logic          seq_last;
   logic          window_full;
   logic [15:0]   seq_count;

   always #5 clk = ~clk;

   cnn_feature_seq_buffer #(
      .DATA_WIDTH (DW),
      .FEAT_SIZE  (FS),
      .SEQ_LEN    (SL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .feat_in_data  (feat_in_data),
      .feat_in_valid (feat_in_valid),
      .feat_in_ready (feat_in_ready),
      .seq_flush     (seq_flush),
      .seq_data      (seq_data),
      .seq_valid     (seq_valid),
      .seq_ready     (seq_ready),
      .seq_dir       (seq_dir),
      .seq_step      (seq_step),
      .seq_feat_idx  (seq_feat_idx),
      .seq_first     (seq_first),
      .seq_last      (seq_last),
      .window_full   (window_full),
      .seq_count     (seq_count)
   );

   typedef logic [FS-1:0][DW-1:0] frame_t;
   typedef struct packed {
      logic [DW-1:0] data;
      logic          dir;
      logic [2:0]    step;
      logic [1:0]    feat;
      logic          first;
      logic          last;
   } exp_t;
   typedef struct {
      int          words;
      bit          flush;
      bit          exp_full;
      bit          exp_valid;
      logic [15:0] exp_cnt_before;
      logic [15:0] exp_cnt_after;
   } vec_t;

   frame_t        win_q[$];
   exp_t          exp_q[$];
   frame_t        cur_frame;
   int            cur_cnt = 0;
   logic [15:0]   exp_count = '0;
   int            n_checks = 0;
   int            n_pass = 0;
   int            first_cnt, last_cnt, fire_cnt;
   bit            in_acc;
   logic [DW-1:0] next_word = 16'd1;
   vec_t          vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
   endtask

   task automatic model_clear();
      win_q.delete();
      exp_q.delete();
      cur_cnt = 0;
   endtask

   // A completed frame enters the window; a full window yields the whole expected replay.
   task automatic model_push_frame(input frame_t fr);
      exp_t e;
      win_q.push_back(fr);
      if (win_q.size() > SL) void'(win_q.pop_front());
      if (win_q.size() == SL) begin
         for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < SL; t++) begin
               for (int f = 0; f < FS; f++) begin
                  e.data  = win_q[(p == 0) ? t : SL - 1 - t][f];
                  e.dir   = (p == 1);
                  e.step  = 3'(t);
                  e.feat  = 2'(f);
                  e.first = (t == 0) && (f == 0);
                  e.last  = (t == SL - 1) && (f == FS - 1);
                  exp_q.push_back(e);
               end
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, then apply the handshakes the rising edge will see.
   task automatic cycle();
      exp_t e;
      bit   exp_rdy;
      @(negedge clk);
      in_acc  = 1'b0;
      exp_rdy = (exp_q.size() == 0) && !seq_flush;
      check("seq_valid", seq_valid, exp_q.size() != 0);
      check("feat_in_ready", feat_in_ready, exp_rdy);
      check("window_full", window_full, win_q.size() == SL);
      check("seq_count", seq_count, exp_count);
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         check("seq_data", seq_data, e.data);
         check("sideband", {seq_dir, seq_step, seq_feat_idx, seq_first, seq_last},
               {e.dir, e.step, e.feat, e.first, e.last});
      end
      if (seq_flush) begin
         model_clear();
      end else begin
         if (exp_q.size() != 0 && seq_ready) begin
            e = exp_q.pop_front();
            fire_cnt++;
            if (seq_first) first_cnt++;
            if (seq_last) last_cnt++;
            if (e.last && e.dir) exp_count++;
         end
         if (feat_in_valid && exp_rdy) begin
            cur_frame[cur_cnt] = feat_in_data;
            cur_cnt++;
            in_acc = 1'b1;
            if (cur_cnt == FS) begin
               cur_cnt = 0;
               model_push_frame(cur_frame);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         feat_in_valid = 1'b1;
         feat_in_data  = next_word;
         for (int k = 0; k < 200; k++) begin
            cycle();
            if (in_acc) break;
         end
         if (!in_acc) check("feed_timeout", 0, 1);
         next_word = next_word + 16'd1;
      end
      feat_in_valid = 1'b0;
   endtask

   task automatic drain(output int cycles);
      seq_ready     = 1'b1;
      feat_in_valid = 1'b0;
      cycles        = 0;
      while (exp_q.size() != 0 && cycles < 1000) begin
         cycle();
         cycles++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, seq_valid, 0);
      check({tag, "_data"}, seq_data, 0);
      check({tag, "_side"}, {seq_dir, seq_step, seq_feat_idx, seq_first, seq_last}, 0);
      check({tag, "_full"}, window_full, 0);
      check({tag, "_count"}, seq_count, 0);
      check({tag, "_ready"}, feat_in_ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      vecs[0] = '{23, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      vecs[1] = '{1,  1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
      vecs[2] = '{3,  1'b0, 1'b1, 1'b1, 16'd1, 16'd2};
      vecs[3] = '{2,  1'b1, 1'b0, 1'b0, 16'd2, 16'd2};
      vecs[4] = '{21, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2};
      vecs[5] = '{3,  1'b0, 1'b1, 1'b1, 16'd2, 16'd3};

      #2 rst_n = 1'b0;
      #2 check_reset_vals("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      seq_ready = 1'b1;

      for (int v = 0; v < 6; v++) begin
         feed(vecs[v].words);
         if (vecs[v].flush) begin
            feat_in_valid = 1'b1;
            feat_in_data  = 16'hDEAD;
            seq_flush     = 1'b1;
            cycle();
            seq_flush     = 1'b0;
            feat_in_valid = 1'b0;
         end
         #2;
         check($sformatf("vec%0d_full", v), window_full, vecs[v].exp_full);
         check($sformatf("vec%0d_valid", v), seq_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d_cnt", v), seq_count, vecs[v].exp_cnt_before);
         if (vecs[v].exp_valid) begin
            drain(cyc);
            check($sformatf("vec%0d_cycles", v), cyc, REPLAY);
            check($sformatf("vec%0d_cnt_after", v), seq_count, vecs[v].exp_cnt_after);
         end
      end

      first_cnt = 0;
      last_cnt  = 0;
      fire_cnt  = 0;
      feed(3);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         seq_ready = (i % 3) != 2;
         cycle();
      end
      check("stall_first", first_cnt, 2);
      check("stall_last", last_cnt, 2);
      check("stall_words", fire_cnt, REPLAY);
      check("stall_count", seq_count, 16'd4);

      seq_ready = 1'b1;
      feed(3);
      repeat (10) cycle();
      seq_flush = 1'b1;
      cycle();
      seq_flush = 1'b0;
      #2;
      check("flush_valid", seq_valid, 0);
      check("flush_full", window_full, 0);
      check("flush_count", seq_count, 16'd4);
      feed(21);
      #2 check("flush_refill_valid", seq_valid, 0);
      feed(3);
      #2 check("flush_refill_start", seq_valid, 1);
      drain(cyc);
      check("flush_refill_count", seq_count, 16'd5);

      for (int i = 0; i < 2500; i++) begin
         feat_in_valid = $urandom_range(0, 3) != 0;
         feat_in_data  = 16'($urandom);
         seq_ready     = $urandom_range(0, 2) != 0;
         seq_flush     = $urandom_range(0, 299) == 0;
         cycle();
      end
      seq_flush = 1'b0;
      drain(cyc);

      seq_flush = 1'b1;
      cycle();
      seq_flush = 1'b0;
      feed(24);
      repeat (30) cycle();
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_reset");
      model_clear();
      exp_count = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      next_word = 16'd1;
      feed(24);
      #2;
      check("post_reset_valid", seq_valid, 1);
      check("post_reset_first_word", seq_data, 16'h0001);
      drain(cyc);
      check("post_reset_cycles", cyc, REPLAY);
      check("post_reset_count", seq_count, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
